// File: rtl/fdivexpsub.sv
// Exponent subtract and serial prenormalization front end for the iterative FP divider.
// Subnormal significands are left-shifted one bit per cycle until their MSB is set; the
// shift counts are folded into the biased quotient exponent on the way into DONE.
module fdivexpsub #(
    parameter int unsigned NE   = 11,
    parameter int unsigned NF   = 52,
    parameter int unsigned BIAS = 1023
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic            Flush,
    input  logic [NE-1:0]   Xe,
    input  logic [NE-1:0]   Ye,
    input  logic [NF:0]     Xm,
    input  logic [NF:0]     Ym,
    input  logic            XZero,
    input  logic            YZero,
    output logic            Busy,
    output logic            Done,
    output logic [NE+1:0]   Qe,
    output logic [NF:0]     XmNorm,
    output logic [NF:0]     YmNorm,
    output logic            DivByZero
);

    localparam int unsigned LW = $clog2(NF + 1) + 1;
    localparam int unsigned QW = NE + 2;

    typedef enum logic [1:0] {StIdle, StNorm, StDone} state_e;

    state_e          state_q, state_d;
    logic [NF:0]     xm_q, ym_q;
    logic [NE-1:0]   xe_q, ye_q;
    logic [LW-1:0]   xlz_q, ylz_q;
    logic            xz_q, yz_q;

    logic            x_ok, y_ok, both_ok;
    logic [QW-1:0]   qe_calc;
    logic            accept;

    // Normalization status and the quotient exponent from the current shift counts.
    // An all-zero significand is treated as finished so a mislabelled zero cannot spin forever.
    always_comb begin
        x_ok    = xz_q | xm_q[NF] | ~(|xm_q);
        y_ok    = yz_q | ym_q[NF] | ~(|ym_q);
        both_ok = x_ok & y_ok;
        qe_calc = QW'(xe_q) - QW'(xlz_q) - QW'(ye_q) + QW'(ylz_q) + QW'(BIAS);
        if (xz_q | yz_q) begin
            qe_calc = '0;
        end
        accept  = (state_q == StIdle) & Start & ~Flush;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Flush overrides everything, including Start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Start) state_d = StNorm;
            StNorm:  if (both_ok) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (Flush) begin
            state_d = StIdle;
        end
    end

    // Operand latch, serial shift, and result capture on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xm_q      <= '0;
            ym_q      <= '0;
            xe_q      <= '0;
            ye_q      <= '0;
            xlz_q     <= '0;
            ylz_q     <= '0;
            xz_q      <= 1'b0;
            yz_q      <= 1'b0;
            Qe        <= '0;
            XmNorm    <= '0;
            YmNorm    <= '0;
            DivByZero <= 1'b0;
        end else if (accept) begin
            xm_q  <= Xm;
            ym_q  <= Ym;
            // Subnormals share the exponent of the smallest normal.
            xe_q  <= (Xe == '0) ? NE'(1) : Xe;
            ye_q  <= (Ye == '0) ? NE'(1) : Ye;
            xlz_q <= '0;
            ylz_q <= '0;
            xz_q  <= XZero;
            yz_q  <= YZero;
        end else if (state_q == StNorm && !Flush) begin
            if (both_ok) begin
                Qe        <= qe_calc;
                XmNorm    <= xm_q;
                YmNorm    <= ym_q;
                DivByZero <= yz_q & ~xz_q;
            end else begin
                if (!x_ok) begin
                    xm_q  <= {xm_q[NF-1:0], 1'b0};
                    xlz_q <= xlz_q + LW'(1);
                end
                if (!y_ok) begin
                    ym_q  <= {ym_q[NF-1:0], 1'b0};
                    ylz_q <= ylz_q + LW'(1);
                end
            end
        end
    end

    // Status outputs decoded from the state; a flushed DONE cycle does not pulse.
    always_comb begin
        Busy = (state_q != StIdle);
        Done = (state_q == StDone) & ~Flush;
    end

endmodule

// File: tb/tb_fdivexpsub.sv
// Self-checking bench for fdivexpsub: directed table, randomized operands against a
// behavioural model, and hand-written Start-while-busy, Flush and mid-run reset sequences.
module tb_fdivexpsub;

    localparam int NE = 11;
    localparam int NF = 52;
    localparam int BIAS = 1023;
    localparam int MAXCYC = 200;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            Start = 1'b0;
    logic            Flush = 1'b0;
    logic [NE-1:0]   Xe = '0, Ye = '0;
    logic [NF:0]     Xm = '0, Ym = '0;
    logic            XZero = 1'b0, YZero = 1'b0;
    logic            Busy, Done, DivByZero;
    logic [NE+1:0]   Qe;
    logic [NF:0]     XmNorm, YmNorm;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [NE-1:0] xe, ye;
        logic [NF:0]   xm, ym;
        logic          xz, yz;
        logic [NE+1:0] qe;
        int            lat;
        logic          dbz;
    } vec_t;

    vec_t tbl[8];

    fdivexpsub #(.NE(NE), .NF(NF), .BIAS(BIAS)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Flush(Flush),
        .Xe(Xe), .Ye(Ye), .Xm(Xm), .Ym(Ym), .XZero(XZero), .YZero(YZero),
        .Busy(Busy), .Done(Done), .Qe(Qe), .XmNorm(XmNorm), .YmNorm(YmNorm),
        .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: count leading zeros, shift them out, fold into exponent arithmetic.
    function automatic int clz(input logic [NF:0] m, input logic z);
        int n = 0;
        if (z || m == '0) return 0;
        while (m[NF] == 1'b0) begin
            m = m << 1;
            n++;
        end
        return n;
    endfunction

    function automatic logic [NF:0] norm(input logic [NF:0] m, input logic z);
        return m << clz(m, z);
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int xl = clz(v.xm, v.xz);
        int yl = clz(v.ym, v.yz);
        int xeff = (v.xe == 0) ? 1 : int'(v.xe);
        int yeff = (v.ye == 0) ? 1 : int'(v.ye);
        int q = (xeff - xl) - (yeff - yl) + BIAS;
        r.qe  = (v.xz || v.yz) ? '0 : q[NE+1:0];
        r.lat = 2 + ((xl > yl) ? xl : yl);
        r.dbz = v.yz & ~v.xz;
        return r;
    endfunction

    function automatic vec_t mk(input int xe, input int ye, input logic [NF:0] xm,
                                input logic [NF:0] ym, input bit xz, input bit yz,
                                input int qe, input int lat, input bit dbz);
        vec_t v;
        v.xe = xe[NE-1:0]; v.ye = ye[NE-1:0]; v.xm = xm; v.ym = ym;
        v.xz = xz; v.yz = yz; v.qe = qe[NE+1:0]; v.lat = lat; v.dbz = dbz;
        return v;
    endfunction

    task automatic start_op(input vec_t v);
        Xe = v.xe; Ye = v.ye; Xm = v.xm; Ym = v.ym; XZero = v.xz; YZero = v.yz;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    // Run one operation and check latency, outputs and the single-cycle Done pulse.
    // With poke set, garbage Start pulses are issued during NORM and on the Done cycle.
    task automatic apply(input vec_t v, input bit poke);
        int cyc = 1;
        int pulses = 0;
        start_op(v);
        while (!Done && cyc < MAXCYC) begin
            if (poke && (cyc % 5 == 0)) begin
                Start = 1'b1; Xe = ~v.xe; Xm = NF'($urandom); XZero = ~v.xz;
            end else begin
                Start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        Start = 1'b0;
        check("latency", 64'(cyc), 64'(v.lat));
        check("qe", 64'(Qe), 64'(v.qe));
        check("dbz", 64'(DivByZero), 64'(v.dbz));
        check("xmnorm", 64'(XmNorm), 64'(norm(v.xm, v.xz)));
        check("ymnorm", 64'(YmNorm), 64'(norm(v.ym, v.yz)));
        if (poke) begin
            Start = 1'b1; Xe = ~v.xe; Ye = ~v.ye;
        end
        @(posedge clk); #1;
        Start = 1'b0;
        check("done_pulse", 64'({Done, Busy}), 64'(0));
        if (poke) begin
            repeat (4) begin
                @(posedge clk); #1;
                if (Done || Busy) pulses++;
            end
            check("poke_idle", 64'(pulses), 64'(0));
            check("poke_qe", 64'(Qe), 64'(v.qe));
        end
    endtask

    initial begin
        vec_t v, r;
        int dcnt;
        int cyc;

        tbl[0] = mk(1023, 1023, 53'(1) << 52, 53'(1) << 52, 0, 0, 1023, 2, 0);
        tbl[1] = mk(2046, 1, 53'(1) << 52, 53'(1) << 52, 0, 0, 3068, 2, 0);
        tbl[2] = mk(1, 2046, 53'(1) << 52, 53'(1) << 52, 0, 0, 13'h1C02, 2, 0);
        tbl[3] = mk(0, 1023, 53'(1) << 51, 53'(1) << 52, 0, 0, 0, 3, 0);
        tbl[4] = mk(0, 2046, 53'(1), 53'(1) << 52, 0, 0, -1074, 54, 0);
        tbl[5] = mk(1023, 0, 53'(1) << 52, 53'(0), 0, 1, 0, 2, 1);
        tbl[6] = mk(0, 0, 53'(0), 53'(0), 1, 1, 0, 2, 0);
        tbl[7] = mk(1023, 0, 53'h1F_0000_0000_0000, 53'(1) << 49, 0, 0, 2048, 5, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({Busy, Done, DivByZero, Qe}), 64'(0));
        check("reset_xm", 64'(XmNorm), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i], 1'b0);
        end

        // Random operands, roughly a third subnormal and an occasional zero.
        for (int i = 0; i < 30; i++) begin
            v.xe = NE'($urandom_range(1, 2046));
            v.ye = NE'($urandom_range(1, 2046));
            v.xm = {1'b1, 52'({$urandom, $urandom})};
            v.ym = {1'b1, 52'({$urandom, $urandom})};
            if ($urandom_range(0, 2) == 0) begin
                v.xe = '0;
                v.xm = v.xm >> $urandom_range(1, NF);
            end
            if ($urandom_range(0, 2) == 0) begin
                v.ye = '0;
                v.ym = v.ym >> $urandom_range(1, NF);
            end
            v.xz = ($urandom_range(0, 9) == 0);
            v.yz = ($urandom_range(0, 9) == 0);
            if (v.xz) begin v.xe = '0; v.xm = '0; end
            if (v.yz) begin v.ye = '0; v.ym = '0; end
            r = model(v);
            apply(r, 1'b0);
        end

        // Start pulses while busy and on the Done cycle must be ignored.
        apply(tbl[4], 1'b1);

        // Flush partway through a long normalization: no Done, outputs hold.
        apply(tbl[0], 1'b0);
        start_op(tbl[4]);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        check("flush_busy", 64'(Busy), 64'(0));
        dcnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (Done || Busy) dcnt++;
        end
        check("flush_nodone", 64'(dcnt), 64'(0));
        check("flush_qe", 64'(Qe), 64'(1023));
        check("flush_xm", 64'(XmNorm), 64'(53'(1) << 52));

        // Asynchronous reset in the middle of NORM clears everything immediately.
        start_op(tbl[4]);
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_state", 64'({Busy, Done, DivByZero, Qe}), 64'(0));
        check("rst_mid_xm", 64'(XmNorm), 64'(0));
        check("rst_mid_ym", 64'(YmNorm), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        apply(tbl[7], 1'b0);
        apply(tbl[1], 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
